auth_seq_ctrl: RTL and testbench
================================

Name: auth_seq_ctrl

Overview:
Sequences a PIN-style authentication attempt from one-cycle button pulses produced by the rising-edge detectors.
- Collects CODE_LEN digits into an entry buffer and compares them against a static key.
- Drives grant, error and lockout indications.
- Enforces a failed-attempt limit with a timed lockout and an inactivity timeout.
- Sits between the synchronised/edge-detected pushbutton front end and the top-level status outputs.

Parameters:
CODE_LEN, 4, digits per code (legal range 2 or more)
DIGIT_W, 2, bits per digit
NUM_TRIES, 3, consecutive failures that trigger lockout (legal range 1 or more)
HOLD_CYCLES, 1000, cycles that unlock/error stay asserted
LOCK_CYCLES, 10000, cycles that lockout lasts
TIMEOUT_CYCLES, 5000, inactivity limit during entry

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
digit_in  in  DIGIT_W  digit value, sampled only in the cycle enter_pulse=1
enter_pulse  in  1  one-cycle pulse: commit digit_in
clear_pulse  in  1  one-cycle pulse: abandon current entry
key_in  in  CODE_LEN*DIGIT_W  stored key, first digit in MSBs, static, sampled in CHECK
unlock  out  1  access granted (registered)
error  out  1  wrong code (registered)
locked  out  1  lockout active (registered)
digit_cnt  out  clog2(CODE_LEN+1)  digits captured in current attempt
fail_cnt  out  clog2(NUM_TRIES+1)  consecutive failures
state_o  out  3  FSM state: IDLE=0, ENTRY=1, CHECK=2, GRANT=3, FAIL=4, LOCK=5

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All outputs 0. Entry buffer 0. Timer 0.
- Entry buffer shifts left on each accepted digit (buf <= {buf, digit_in}), so the first digit ends in the MSBs.
- A single shared timer serves timeout and hold/lock durations. It clears on every state change and on every accepted digit.
- IDLE:
  - enter_pulse=1 and clear_pulse=0 -> capture digit, digit_cnt=1, go to ENTRY.
  - clear_pulse alone -> no effect.
  - Both pulses high -> clear wins, nothing captured.
- ENTRY:
  - clear_pulse=1 (wins over enter) -> buffer=0, digit_cnt=0, go to IDLE. fail_cnt unchanged.
  - enter_pulse=1 -> capture digit, digit_cnt+1. If the new count equals CODE_LEN, go to CHECK.
  - Timer reaches TIMEOUT_CYCLES-1 with no pulse -> buffer and digit_cnt cleared, go to IDLE. Not counted as a failure.
- CHECK: lasts exactly 1 cycle; all pulses ignored.
  - Buffer equals key_in -> fail_cnt=0, go to GRANT.
  - Mismatch, fail_cnt+1 == NUM_TRIES -> fail_cnt+1, go to LOCK.
  - Mismatch otherwise -> fail_cnt+1, go to FAIL.
  - digit_cnt and buffer clear on CHECK exit.
- GRANT: unlock=1 for exactly HOLD_CYCLES cycles, then go to IDLE. Pulses ignored.
- FAIL: error=1 for exactly HOLD_CYCLES cycles, then go to IDLE. Pulses ignored.
- LOCK: locked=1 for exactly LOCK_CYCLES cycles. On exit, fail_cnt=0 and go to IDLE. All pulses, including clear, ignored.
- Latency:
  - Final enter_pulse at cycle N -> state_o=CHECK at N+1 -> unlock, error or locked asserts at N+2.
  - unlock, error and locked are mutually exclusive, and each mirrors its state one-hot.
- Pulses arriving in non-accepting states are dropped, not queued.
- The timer must not wrap. Its width is sized for the maximum of HOLD_CYCLES, LOCK_CYCLES and TIMEOUT_CYCLES.
- Reset asserted mid-operation (including during LOCK) returns to full reset values immediately.

Test Plan:
Bench parameters: CODE_LEN=4, DIGIT_W=2, NUM_TRIES=3, HOLD_CYCLES=4, LOCK_CYCLES=8, TIMEOUT_CYCLES=16, key_in=8'b10_01_11_00.
1. Correct code: enter digits 2,1,3,0 on spaced pulses -> CHECK one cycle after the 4th pulse; unlock=1 for exactly 4 cycles starting 2 cycles after the 4th pulse; fail_cnt=0; then IDLE.
2. Wrong code twice (2,1,3,1): each attempt -> error=1 for 4 cycles; fail_cnt goes 1 then 2; a pulse during FAIL is ignored (digit_cnt stays 0).
3. Third wrong attempt -> locked=1 for exactly 8 cycles; enter and clear pulses during LOCK are ignored; on exit fail_cnt=0; a following correct code grants.
4. Clear and timeout: enter 2,1 then clear -> IDLE, digit_cnt=0, fail_cnt unchanged. Enter 2 then idle for 16 cycles -> IDLE, no error, fail_cnt unchanged.
5. Simultaneous enter_pulse and clear_pulse in ENTRY with digit_cnt=2 -> IDLE, digit not captured. Same in IDLE -> stays IDLE, digit_cnt=0.
6. Assert reset during GRANT and again during LOCK -> all outputs 0 and state_o=0 in the same cycle as reset; a correct code after reset release grants.

Source files
------------

// File: rtl/auth_seq_ctrl.sv
// auth_seq_ctrl: PIN entry sequencer with key compare, grant/error hold, failure lockout and inactivity timeout
module auth_seq_ctrl #(
  parameter int CODE_LEN       = 4,
  parameter int DIGIT_W        = 2,
  parameter int NUM_TRIES      = 3,
  parameter int HOLD_CYCLES    = 1000,
  parameter int LOCK_CYCLES    = 10000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DIGIT_W-1:0]                   digit_in,
  input  logic                                 enter_pulse,
  input  logic                                 clear_pulse,
  input  logic [CODE_LEN*DIGIT_W-1:0]          key_in,
  output logic                                 unlock,
  output logic                                 error,
  output logic                                 locked,
  output logic [$clog2(CODE_LEN+1)-1:0]        digit_cnt,
  output logic [$clog2(NUM_TRIES+1)-1:0]       fail_cnt,
  output logic [2:0]                           state_o
);
  localparam int KW = CODE_LEN * DIGIT_W;
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(NUM_TRIES + 1);
  localparam int T1 = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TM = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TM + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, CHECK = 3'd2, GRANT = 3'd3, FAIL = 3'd4, LOCK = 3'd5} state_t;
  state_t        state;
  logic [KW-1:0] entry_buf;
  logic [TW-1:0] timer;
  logic [KW-1:0] buf_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [FW-1:0] fail_nxt;
  assign buf_nxt  = {entry_buf[KW-DIGIT_W-1:0], digit_in};
  assign cnt_nxt  = digit_cnt + 1'b1;
  assign fail_nxt = fail_cnt + 1'b1;
  assign state_o  = state;
  // Timer saturates by default; every state change or accepted digit overrides it to zero below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      entry_buf <= '0;
      timer     <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      unlock    <= 1'b0;
      error     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      timer <= (timer == {TW{1'b1}}) ? timer : timer + 1'b1;
      case (state)
        IDLE: if (enter_pulse && !clear_pulse) begin
          entry_buf <= buf_nxt;
          digit_cnt <= CW'(1);
          timer     <= '0;
          state     <= ENTRY;
        end
        ENTRY: if (clear_pulse || (!enter_pulse && timer == TW'(TIMEOUT_CYCLES - 1))) begin
          entry_buf <= '0;
          digit_cnt <= '0;
          timer     <= '0;
          state     <= IDLE;
        end else if (enter_pulse) begin
          entry_buf <= buf_nxt;
          digit_cnt <= cnt_nxt;
          timer     <= '0;
          if (cnt_nxt == CW'(CODE_LEN)) state <= CHECK;
        end
        CHECK: begin
          entry_buf <= '0;
          digit_cnt <= '0;
          timer     <= '0;
          if (entry_buf == key_in) begin
            fail_cnt <= '0;
            unlock   <= 1'b1;
            state    <= GRANT;
          end else if (fail_nxt == FW'(NUM_TRIES)) begin
            fail_cnt <= fail_nxt;
            locked   <= 1'b1;
            state    <= LOCK;
          end else begin
            fail_cnt <= fail_nxt;
            error    <= 1'b1;
            state    <= FAIL;
          end
        end
        GRANT: if (timer == TW'(HOLD_CYCLES - 1)) begin
          unlock <= 1'b0;
          timer  <= '0;
          state  <= IDLE;
        end
        FAIL: if (timer == TW'(HOLD_CYCLES - 1)) begin
          error <= 1'b0;
          timer <= '0;
          state <= IDLE;
        end
        LOCK: if (timer == TW'(LOCK_CYCLES - 1)) begin
          locked   <= 1'b0;
          fail_cnt <= '0;
          timer    <= '0;
          state    <= IDLE;
        end
        default: begin
          unlock <= 1'b0;
          error  <= 1'b0;
          locked <= 1'b0;
          timer  <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_auth_seq_ctrl.sv
// tb_auth_seq_ctrl: directed stimulus with a cycle-tagged expectation queue drained by an independent monitor
module tb_auth_seq_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2, S_GRANT = 3'd3, S_FAIL = 3'd4, S_LOCK = 3'd5;
  localparam logic [7:0] KEY = 8'b10_01_11_00;
  localparam logic [7:0] BAD = 8'b10_01_11_01;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] digit_in;
  logic       enter_pulse;
  logic       clear_pulse;
  logic       unlock;
  logic       error;
  logic       locked;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;
  int         cyc = 0;
  int         vectors = 0;
  int         fails = 0;
  typedef struct {
    int          cyc;
    logic [10:0] want;
    string       nm;
  } exp_t;
  exp_t q[$];
  auth_seq_ctrl #(
    .CODE_LEN(4), .DIGIT_W(2), .NUM_TRIES(3),
    .HOLD_CYCLES(4), .LOCK_CYCLES(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .enter_pulse(enter_pulse),
    .clear_pulse(clear_pulse), .key_in(KEY), .unlock(unlock), .error(error),
    .locked(locked), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .state_o(state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(input string nm, input logic [10:0] want);
    logic [10:0] got;
    got = {state_o, unlock, error, locked, digit_cnt, fail_cnt};
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d: got st=%0d u/e/l=%b dc=%0d fc=%0d, want st=%0d u/e/l=%b dc=%0d fc=%0d",
               nm, cyc, got[10:8], got[7:5], got[4:2], got[1:0], want[10:8], want[7:5], want[4:2], want[1:0]);
    end
  endtask
  always begin
    @(negedge clk);
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) cmp(q[0].nm, q.pop_front().want);
  end
  task automatic push(input int c, input logic [2:0] st, input logic [2:0] fl, input logic [2:0] dc, input logic [1:0] fc, input string nm);
    q.push_back('{c, {st, fl, dc, fc}, nm});
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic en, input logic cl, input logic [1:0] d);
    enter_pulse = en;
    clear_pulse = cl;
    digit_in    = d;
    @(negedge clk);
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    digit_in    = 2'd0;
  endtask
  task automatic enter_code(input logic [7:0] code, input logic [1:0] fc, input string nm, output int c);
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      push(c + 1, (i < 3) ? S_ENTRY : S_CHECK, 3'b000, 3'(i + 1), fc, nm);
      press(1'b1, 1'b0, code[7-2*i -: 2]);
      if (i < 3) idle(1);
    end
  endtask
  task automatic attempt(input logic [7:0] code, input logic [1:0] fc0, input logic [2:0] st, input logic [2:0] fl,
                         input int n, input logic [1:0] fcd, input logic [1:0] fca, input bit poke, input string nm);
    int c;
    enter_code(code, fc0, nm, c);
    for (int k = 0; k < n; k++) push(c + 2 + k, st, fl, 3'd0, fcd, nm);
    push(c + 2 + n, S_IDLE, 3'b000, 3'd0, fca, {nm, "_exit"});
    for (int k = 0; k <= n; k++)
      if (poke && k >= 1 && k <= 3) press(k != 2, k >= 2, 2'(k));
      else idle(1);
  endtask
  initial begin
    int c;
    reset = 1'b0;
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    digit_in = 2'd0;
    idle(2);
    cmp("reset", 11'd0);
    reset = 1'b1;
    idle(2);
    attempt(KEY, 2'd0, S_GRANT, 3'b100, 4, 2'd0, 2'd0, 1'b0, "grant");
    attempt(BAD, 2'd0, S_FAIL, 3'b010, 4, 2'd1, 2'd1, 1'b1, "fail1");
    attempt(BAD, 2'd1, S_FAIL, 3'b010, 4, 2'd2, 2'd2, 1'b1, "fail2");
    attempt(BAD, 2'd2, S_LOCK, 3'b001, 8, 2'd3, 2'd0, 1'b1, "lock");
    attempt(KEY, 2'd0, S_GRANT, 3'b100, 4, 2'd0, 2'd0, 1'b0, "grant_after_lock");
    attempt(BAD, 2'd0, S_FAIL, 3'b010, 4, 2'd1, 2'd1, 1'b0, "fail_pre_clear");
    c = cyc; push(c + 1, S_ENTRY, 3'b000, 3'd1, 2'd1, "clr_d1"); press(1'b1, 1'b0, 2'd2);
    c = cyc; push(c + 1, S_ENTRY, 3'b000, 3'd2, 2'd1, "clr_d2"); press(1'b1, 1'b0, 2'd1);
    c = cyc; push(c + 1, S_IDLE,  3'b000, 3'd0, 2'd1, "clear");  press(1'b0, 1'b1, 2'd0);
    c = cyc;
    push(c + 1,  S_ENTRY, 3'b000, 3'd1, 2'd1, "to_start");
    push(c + 16, S_ENTRY, 3'b000, 3'd1, 2'd1, "to_last_entry");
    push(c + 17, S_IDLE,  3'b000, 3'd0, 2'd1, "timeout");
    push(c + 18, S_IDLE,  3'b000, 3'd0, 2'd1, "timeout_after");
    press(1'b1, 1'b0, 2'd2);
    idle(17);
    c = cyc; push(c + 1, S_ENTRY, 3'b000, 3'd1, 2'd1, "both_d1"); press(1'b1, 1'b0, 2'd2);
    c = cyc; push(c + 1, S_ENTRY, 3'b000, 3'd2, 2'd1, "both_d2"); press(1'b1, 1'b0, 2'd1);
    c = cyc; push(c + 1, S_IDLE,  3'b000, 3'd0, 2'd1, "both_entry"); press(1'b1, 1'b1, 2'd3);
    c = cyc; push(c + 1, S_IDLE,  3'b000, 3'd0, 2'd1, "both_idle"); press(1'b1, 1'b1, 2'd3);
    c = cyc; push(c + 1, S_IDLE,  3'b000, 3'd0, 2'd1, "clear_idle"); press(1'b0, 1'b1, 2'd0);
    attempt(KEY, 2'd1, S_GRANT, 3'b100, 4, 2'd0, 2'd0, 1'b0, "grant_after_both");
    enter_code(KEY, 2'd0, "rst_grant_code", c);
    push(c + 2, S_GRANT, 3'b100, 3'd0, 2'd0, "rst_grant_pre");
    idle(2);
    #2 reset = 1'b0;
    #1 cmp("rst_in_grant", 11'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    attempt(KEY, 2'd0, S_GRANT, 3'b100, 4, 2'd0, 2'd0, 1'b0, "grant_after_rst1");
    attempt(BAD, 2'd0, S_FAIL, 3'b010, 4, 2'd1, 2'd1, 1'b0, "rl_fail1");
    attempt(BAD, 2'd1, S_FAIL, 3'b010, 4, 2'd2, 2'd2, 1'b0, "rl_fail2");
    enter_code(BAD, 2'd2, "rst_lock_code", c);
    push(c + 2, S_LOCK, 3'b001, 3'd0, 2'd3, "rst_lock_pre");
    idle(4);
    #2 reset = 1'b0;
    #1 cmp("rst_in_lock", 11'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    attempt(KEY, 2'd0, S_GRANT, 3'b100, 4, 2'd0, 2'd0, 1'b0, "grant_after_rst2");
    for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
    if (q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: cyc=%0d, want finish before 5000", cyc);
    $fatal(1);
  end
endmodule
